// File: rtl/elevator_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : elevator_motion_ctrl
// Brief   : SCAN-order floor scheduler driving stepper_motor direction, with
//           step-counted floor tracking and timed door hold. Optional ESTOP_EN
//           adds an estop input that freezes motion and timers.
// Rev     : 1.0  initial release
// ============================================================================
module elevator_motion_ctrl #(
    parameter  int NUM_FLOORS      = 4,
    parameter  int STEPS_PER_FLOOR = 16,
    parameter  int DOOR_CYCLES     = 20,
    localparam int FW              = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] req,
    output logic [1:0]            direction,
    output logic [FW-1:0]         cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  busy
);

    localparam int SW = $clog2(STEPS_PER_FLOOR);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    localparam logic [SW-1:0] c_STEP_LAST = SW'(STEPS_PER_FLOOR - 1);
    localparam logic [DW-1:0] c_DOOR_LOAD = DW'(DOOR_CYCLES - 1);
    localparam logic [1:0]    c_DIR_UP    = 2'b11;
    localparam logic [1:0]    c_DIR_DOWN  = 2'b10;
    localparam logic [1:0]    c_DIR_STOP  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_dir;
    logic [FW-1:0]           r_floor;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic                    r_door;
    logic                    r_busy;
    logic [SW-1:0]           r_step;
    logic [DW-1:0]           r_dcnt;
    logic                    r_up;

    logic                    w_frz;
    logic                    w_arrive;
    logic [FW-1:0]           w_tgt;
    logic                    w_above_cur;
    logic                    w_below_cur;
    logic                    w_beyond;
    logic [NUM_FLOORS-1:0]   w_req_eff;
    logic [NUM_FLOORS-1:0]   w_clr;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i > int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(f)) r = r | p[i];
        return r;
    endfunction

`ifdef ESTOP_EN
    assign w_frz = estop;
`else
    assign w_frz = 1'b0;
`endif

    assign w_arrive    = ((r_state == S_MOVE_UP) || (r_state == S_MOVE_DOWN)) && (r_step == c_STEP_LAST);
    assign w_tgt       = (r_state == S_MOVE_UP) ? r_floor + FW'(1) : r_floor - FW'(1);
    assign w_above_cur = any_above(r_pending, r_floor);
    assign w_below_cur = any_below(r_pending, r_floor);
    assign w_beyond    = (r_state == S_MOVE_UP) ? any_above(r_pending, w_tgt)
                                                : any_below(r_pending, w_tgt);

    // A call for the floor whose door is open only restarts the door timer.
    always_comb begin
        w_req_eff = req;
        w_clr     = '0;
        if (r_state == S_DOOR_OPEN)
            w_req_eff[r_floor] = 1'b0;
        if (!w_frz) begin
            if ((r_state == S_IDLE) && r_pending[r_floor])
                w_clr[r_floor] = 1'b1;
            if (w_arrive && r_pending[w_tgt])
                w_clr[w_tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dir     <= c_DIR_STOP;
            r_floor   <= '0;
            r_pending <= '0;
            r_door    <= 1'b0;
            r_busy    <= 1'b0;
            r_step    <= '0;
            r_dcnt    <= '0;
            r_up      <= 1'b1;
        end else begin
            r_pending <= (r_pending | w_req_eff) & ~w_clr;
            if (w_frz) begin
                r_dir <= c_DIR_STOP;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_pending[r_floor]) begin
                            r_state <= S_DOOR_OPEN;
                            r_door  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_dcnt  <= c_DOOR_LOAD;
                        end else if (w_above_cur && (r_up || !w_below_cur)) begin
                            r_state <= S_MOVE_UP;
                            r_dir   <= c_DIR_UP;
                            r_busy  <= 1'b1;
                            r_up    <= 1'b1;
                            r_step  <= '0;
                        end else if (w_below_cur) begin
                            r_state <= S_MOVE_DOWN;
                            r_dir   <= c_DIR_DOWN;
                            r_busy  <= 1'b1;
                            r_up    <= 1'b0;
                            r_step  <= '0;
                        end
                    end
                    S_MOVE_UP, S_MOVE_DOWN: begin
                        if (w_arrive) begin
                            r_step  <= '0;
                            r_floor <= w_tgt;
                            if (r_pending[w_tgt]) begin
                                r_state <= S_DOOR_OPEN;
                                r_dir   <= c_DIR_STOP;
                                r_door  <= 1'b1;
                                r_dcnt  <= c_DOOR_LOAD;
                            end else if (w_beyond) begin
                                r_dir <= (r_state == S_MOVE_UP) ? c_DIR_UP : c_DIR_DOWN;
                            end else begin
                                // Reversal is decided from IDLE on the next edge.
                                r_state <= S_IDLE;
                                r_dir   <= c_DIR_STOP;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_step <= r_step + SW'(1);
                            r_dir  <= (r_state == S_MOVE_UP) ? c_DIR_UP : c_DIR_DOWN;
                        end
                    end
                    S_DOOR_OPEN: begin
                        if (req[r_floor]) begin
                            r_dcnt <= c_DOOR_LOAD;
                        end else if (r_dcnt == '0) begin
                            r_state <= S_IDLE;
                            r_door  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_dcnt <= r_dcnt - DW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign direction = r_dir;
    assign cur_floor = r_floor;
    assign pending   = r_pending;
    assign door_open = r_door;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_elevator_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_elevator_motion_ctrl
// Brief   : Self-checking bench for elevator_motion_ctrl (4 floors, 16 steps,
//           20 door cycles) with a floor/position reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_elevator_motion_ctrl;

    localparam int NF   = 4;
    localparam int SPF  = 16;
    localparam int DOOR = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] req = '0;
`ifdef ESTOP_EN
    logic          estop = 1'b0;
`endif
    logic [1:0]    direction;
    logic [1:0]    cur_floor;
    logic [NF-1:0] pending;
    logic          door_open;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_up   = 0;
    int cnt_dn   = 0;
    int cnt_door = 0;

    elevator_motion_ctrl #(
        .NUM_FLOORS      (NF),
        .STEPS_PER_FLOOR (SPF),
        .DOOR_CYCLES     (DOOR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ESTOP_EN
        .estop     (estop),
`endif
        .req       (req),
        .direction (direction),
        .cur_floor (cur_floor),
        .pending   (pending),
        .door_open (door_open),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: car position as floor + ticks into the current leg,
    // motion as a signed step, door as remaining open cycles.
    int          m_floor, m_ticks, m_mov, m_door;
    bit          m_up, m_halt, m_valid;
    logic [NF-1:0] m_pend;

    function automatic bit m_ahead(input int f, input int dir);
        bit r;
        r = 0;
        for (int i = 0; i < NF; i++)
            if (m_pend[i] && ((dir > 0) ? (i > f) : (i < f))) r = 1;
        return r;
    endfunction

    initial begin
        logic [NF-1:0] nreq, clr;
        int            exp_dir;
        bit            frz;
        m_valid = 0;
        forever begin
            @(negedge clk);
            if (direction == 2'b11) cnt_up++;
            if (direction == 2'b10) cnt_dn++;
            if (door_open)          cnt_door++;
            if (m_valid) begin
                exp_dir = m_halt ? 0 : (m_mov > 0) ? 3 : (m_mov < 0) ? 2 : 0;
                chk("model direction", int'(direction), exp_dir);
                chk("model cur_floor", int'(cur_floor), m_floor);
                chk("model pending",   int'(pending),   int'(m_pend));
                chk("model door_open", int'(door_open), int'(m_door > 0));
                chk("model busy",      int'(busy),      int'((m_door > 0) || (m_mov != 0)));
            end
            // Advance the model with the inputs the next rising edge will sample.
            frz = 0;
`ifdef ESTOP_EN
            frz = estop;
`endif
            if (rst) begin
                m_floor = 0; m_ticks = 0; m_mov = 0; m_door = 0;
                m_up = 1; m_halt = 0; m_pend = '0; m_valid = 1;
            end else begin
                nreq = req;
                if (m_door > 0) nreq[m_floor] = 1'b0;
                clr  = '0;
                m_halt = frz;
                if (!frz) begin
                    if (m_door > 0) begin
                        if (req[m_floor]) m_door = DOOR;
                        else              m_door = m_door - 1;
                    end else if (m_mov != 0) begin
                        m_ticks++;
                        if (m_ticks == SPF) begin
                            m_ticks = 0;
                            m_floor = m_floor + m_mov;
                            if (m_pend[m_floor]) begin
                                clr[m_floor] = 1'b1;
                                m_mov  = 0;
                                m_door = DOOR;
                            end else if (!m_ahead(m_floor, m_mov)) begin
                                m_mov = 0;
                            end
                        end
                    end else if (m_pend[m_floor]) begin
                        clr[m_floor] = 1'b1;
                        m_door = DOOR;
                    end else if (m_ahead(m_floor, 1) && (m_up || !m_ahead(m_floor, -1))) begin
                        m_mov = 1; m_up = 1;
                    end else if (m_ahead(m_floor, -1)) begin
                        m_mov = -1; m_up = 0;
                    end
                end
                m_pend = (m_pend | nreq) & ~clr;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_req(input logic [NF-1:0] r);
        req = r;
        cyc();
        req = '0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!busy && !door_open && pending == '0) begin
                done = 1;
                break;
            end
            cyc();
        end
        chk({name, " settle"}, int'(done), 1);
    endtask

    initial begin
        int up0, dn0, door0;

        // Reset state
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset direction", int'(direction), 0);
        chk("reset cur_floor", int'(cur_floor), 0);
        chk("reset pending",   int'(pending),   0);
        chk("reset door_open", int'(door_open), 0);
        chk("reset busy",      int'(busy),      0);

        // Floor 0 -> 2
        up0 = cnt_up; dn0 = cnt_dn; door0 = cnt_door;
        pulse_req(4'b0100);
        chk("t2 pending latched", int'(pending), 4'b0100);
        chk("t2 dir before decide", int'(direction), 0);
        cyc();
        chk("t2 dir after decide", int'(direction), 3);
        wait_idle("t2");
        chk("t2 up cycles",   cnt_up - up0,     32);
        chk("t2 door cycles", cnt_door - door0, 20);
        chk("t2 floor",       int'(cur_floor),  2);

        // SCAN: up to 3 first, then down to 0
        up0 = cnt_up; dn0 = cnt_dn; door0 = cnt_door;
        pulse_req(4'b1001);
        wait_idle("t3");
        chk("t3 up cycles",   cnt_up - up0,     16);
        chk("t3 down cycles", cnt_dn - dn0,     48);
        chk("t3 door cycles", cnt_door - door0, 40);
        chk("t3 floor",       int'(cur_floor),  0);

        // Move to floor 1, then serve floor 1 in place
        pulse_req(4'b0010);
        wait_idle("t4a");
        chk("t4 floor", int'(cur_floor), 1);
        up0 = cnt_up; door0 = cnt_door;
        pulse_req(4'b0010);
        wait_idle("t4b");
        chk("t4 in-place up",   cnt_up - up0,     0);
        chk("t4 in-place door", cnt_door - door0, 20);

        // Repeat call at door cycle 10 extends the hold to 30
        door0 = cnt_door;
        pulse_req(4'b0010);
        cyc();
        chk("t4 door opened", int'(door_open), 1);
        repeat (9) cyc();
        pulse_req(4'b0010);
        chk("t4 reload not latched", int'(pending), 0);
        wait_idle("t4c");
        chk("t4 extended door", cnt_door - door0, 30);

        // Back to floor 0, then reset mid-move at step 7
        pulse_req(4'b0001);
        wait_idle("t5a");
        pulse_req(4'b0010);
        cyc();
        repeat (7) cyc();
        chk("t5 moving before rst", int'(direction), 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5 rst direction", int'(direction), 0);
        chk("t5 rst cur_floor", int'(cur_floor), 0);
        chk("t5 rst pending",   int'(pending),   0);
        chk("t5 rst busy",      int'(busy),      0);

`ifdef ESTOP_EN
        // Emergency stop for 5 cycles at step 8 of a 0 -> 1 move
        up0 = cnt_up;
        pulse_req(4'b0010);
        cyc();
        repeat (8) cyc();
        estop = 1'b1;
        cyc();
        chk("estop direction", int'(direction), 0);
        repeat (4) cyc();
        estop = 1'b0;
        cyc();
        chk("estop resumed", int'(direction), 3);
        wait_idle("estop");
        chk("estop up cycles", cnt_up - up0, 16);
        chk("estop floor", int'(cur_floor), 1);
        pulse_req(4'b0001);
        wait_idle("estop return");
`endif

        // Three stops in one upward sweep
        up0 = cnt_up; door0 = cnt_door;
        pulse_req(4'b1110);
        wait_idle("t6");
        chk("t6 up cycles",   cnt_up - up0,     48);
        chk("t6 door cycles", cnt_door - door0, 60);
        chk("t6 floor",       int'(cur_floor),  3);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
